// File: rtl/audio_sd_out_if.sv
// Signal bundle between the sound source side and the audio output stage.
interface audio_sd_out_if;
  logic        snd_toggle;
  logic [15:0] tandy_snd;
  logic        speaker_in;
  logic        mute;
  logic        aud_l;
  logic        aud_r;
  logic        ramp_done;

  modport master (
    output snd_toggle, tandy_snd, speaker_in, mute,
    input  aud_l, aud_r, ramp_done
  );

  modport slave (
    input  snd_toggle, tandy_snd, speaker_in, mute,
    output aud_l, aud_r, ramp_done
  );
endinterface

// File: rtl/audio_sd_out.sv
// Audio output stage: sample capture, mix/clamp, mute gain ramp, 1st-order sigma-delta.
// Optional high-pass DC blocker between clamp and scale: define AUDIO_DCBLOCK_EN.
module audio_sd_out #(
  parameter int RAMP_SHIFT = 10,
  parameter int SPK_LEVEL  = 8192
) (
  input logic           clk_vga,
  input logic           reset,
  audio_sd_out_if.slave bus
);
  // state     | meaning
  // MUTED     | g = 0, output held at 50% duty
  // RAMP_UP   | g climbs one step per tick toward 256
  // RUN       | g = 256, full gain, ramp_done high
  // RAMP_DOWN | g falls one step per tick toward 0
  localparam logic [1:0] MUTED     = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] RAMP_DOWN = 2'd3;

  function automatic logic signed [15:0] clamp16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  logic [2:0]             tog_ff;
  logic [1:0]             spk_ff;
  logic [1:0]             mute_ff;
  logic                   spk_s;
  logic                   mute_s;
  logic                   load;
  logic [15:0]            hold;
  logic [17:0]            spk_term;
  logic signed [17:0]     mix;
  logic signed [15:0]     s;
  logic signed [15:0]     s_f;
  logic [RAMP_SHIFT-1:0]  cnt;
  logic                   tick;
  logic [1:0]             state;
  logic [8:0]             g;
  logic signed [25:0]     prod;
  logic signed [15:0]     y;
  logic [15:0]            u;
  logic [16:0]            acc;
  logic                   aud;
  logic                   ramp_done;

  assign spk_s  = spk_ff[1];
  assign mute_s = mute_ff[1];
  assign load   = tog_ff[1] ^ tog_ff[2];
  assign tick   = &cnt;

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      tog_ff  <= '0;
      spk_ff  <= '0;
      mute_ff <= '0;
      hold    <= '0;
      cnt     <= '0;
    end else begin
      tog_ff  <= {tog_ff[1:0], bus.snd_toggle};
      spk_ff  <= {spk_ff[0], bus.speaker_in};
      mute_ff <= {mute_ff[0], bus.mute};
      cnt     <= cnt + RAMP_SHIFT'(1);
      if (load)
        hold <= bus.tandy_snd;
    end
  end

  assign spk_term = spk_s ? 18'(SPK_LEVEL) : 18'd0;
  assign mix      = {{2{hold[15]}}, hold} + spk_term;

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset)
      s <= '0;
    else
      s <= clamp16({{6{mix[17]}}, mix});
  end

`ifdef AUDIO_DCBLOCK_EN
  logic signed [23:0] dc;
  logic signed [23:0] dc_shr;
  logic signed [23:0] hp;

  assign dc_shr = dc >>> 8;
  assign hp     = {{8{s[15]}}, s} - dc_shr;

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      dc  <= '0;
      s_f <= '0;
    end else begin
      s_f <= clamp16(hp);
      if (load)
        dc <= dc + {{8{s[15]}}, s} - dc_shr;
    end
  end
`else
  assign s_f = s;
`endif

  // Mute wins over a coincident tick; the gain is kept across direction changes.
  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      state     <= MUTED;
      g         <= '0;
      ramp_done <= 1'b0;
    end else begin
      case (state)
        MUTED: begin
          g <= '0;
          if (!mute_s)
            state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (mute_s)
            state <= RAMP_DOWN;
          else if (tick) begin
            if (g >= 9'd255) begin
              g         <= 9'd256;
              state     <= RUN;
              ramp_done <= 1'b1;
            end else
              g <= g + 9'd1;
          end
        end
        RUN: begin
          g <= 9'd256;
          if (mute_s) begin
            state     <= RAMP_DOWN;
            ramp_done <= 1'b0;
          end
        end
        RAMP_DOWN: begin
          if (!mute_s)
            state <= RAMP_UP;
          else if (tick) begin
            if (g <= 9'd1) begin
              g     <= '0;
              state <= MUTED;
            end else
              g <= g - 9'd1;
          end
        end
        default: begin
          state     <= MUTED;
          g         <= '0;
          ramp_done <= 1'b0;
        end
      endcase
    end
  end

  assign prod = 26'(s_f) * 26'($signed({1'b0, g}));
  assign u    = y ^ 16'h8000;

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      y   <= '0;
      acc <= '0;
      aud <= 1'b0;
    end else begin
      y   <= 16'(prod >>> 8);
      acc <= {1'b0, acc[15:0]} + {1'b0, u};
      aud <= acc[16];
    end
  end

  assign bus.aud_l     = aud;
  assign bus.aud_r     = aud;
  assign bus.ramp_done = ramp_done;
endmodule

// File: tb/tb_audio_sd_out.sv
// Scoreboard bench for audio_sd_out: ramp timing, capture latency, mix/clamp duty, mute ramp, reset.
`timescale 1ns/1ps
module tb_audio_sd_out;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  logic clk_vga = 1'b0;
  logic reset   = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  typedef struct {
    logic        spk;
    logic [15:0] smp;
    int          lo;
    int          hi;
  } exp_t;
  exp_t sb[$];

  audio_sd_out_if bus();

  audio_sd_out #(.RAMP_SHIFT(2), .SPK_LEVEL(8192)) dut (
    .clk_vga (clk_vga),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_vga);
  endtask

  task automatic send(input logic [15:0] smp, input logic spk);
    bus.tandy_snd  = smp;
    bus.speaker_in = spk;
    bus.snd_toggle = ~bus.snd_toggle;
  endtask

  task automatic test_reset;
    int n;
    cyc(5);
    vectors++;
    if (bus.aud_l !== 1'b0) begin
      miscompares++; $display("FAIL reset_aud_l got %b want 0", bus.aud_l);
    end
    vectors++;
    if (bus.aud_r !== 1'b0) begin
      miscompares++; $display("FAIL reset_aud_r got %b want 0", bus.aud_r);
    end
    vectors++;
    if (bus.ramp_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_ramp_done got %b want 0", bus.ramp_done);
    end
    reset = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk_vga);
      n++;
      @(negedge clk_vga);
      if (bus.ramp_done === 1'b1) break;
    end
    vectors++;
    if (n < 1024 || n > 1031) begin
      miscompares++; $display("FAIL ramp_up_time got %0d cycles want 1024..1031", n);
    end
    vectors++;
    if (dut.g !== 9'd256) begin
      miscompares++; $display("FAIL run_gain got %0d want 256", dut.g);
    end
  endtask

  task automatic check_alternating(input string name, input int n);
    logic prev;
    prev = bus.aud_l;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_vga);
      vectors++;
      if (bus.aud_l !== ~prev) begin
        miscompares++; $display("FAIL %s_toggle cycle %0d got %b want %b", name, i, bus.aud_l, ~prev);
      end
      vectors++;
      if (bus.aud_r !== bus.aud_l) begin
        miscompares++; $display("FAIL %s_lr cycle %0d aud_r %b want %b", name, i, bus.aud_r, bus.aud_l);
      end
      prev = bus.aud_l;
    end
  endtask

  task automatic test_silence;
    cyc(10);
    check_alternating("silence", 64);
  endtask

  task automatic test_capture;
    send(16'h1234, 1'b0);
    @(negedge clk_vga);
    vectors++;
    if (dut.hold !== 16'h0000) begin
      miscompares++; $display("FAIL capture_n1 got %h want 0000", dut.hold);
    end
    @(negedge clk_vga);
    vectors++;
    if (dut.hold !== 16'h0000) begin
      miscompares++; $display("FAIL capture_n2 got %h want 0000", dut.hold);
    end
    @(negedge clk_vga);
    vectors++;
    if (dut.hold !== 16'h1234) begin
      miscompares++; $display("FAIL capture_n3 got %h want 1234", dut.hold);
    end
    bus.tandy_snd = 16'h5555;
    cyc(8);
    vectors++;
    if (dut.hold !== 16'h1234) begin
      miscompares++; $display("FAIL no_reload got %h want 1234", dut.hold);
    end
  endtask

  task automatic test_mix;
    logic [15:0] smp_tab [8];
    logic        spk_tab [8];
    exp_t        e;
    int          m, u, ones;
    smp_tab = '{16'h0000, 16'h0000, 16'h1234, 16'h7FFF, 16'h8000, 16'h8000, 16'h7000, 16'hC000};
    spk_tab = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b1};
    for (int i = 0; i < 8; i++) begin
      m = int'($signed(smp_tab[i])) + (spk_tab[i] ? 8192 : 0);
      if (m > 32767) m = 32767;
      if (m < -32768) m = -32768;
      u = (m & 32'hFFFF) ^ 32'h8000;
      e.spk = spk_tab[i];
      e.smp = smp_tab[i];
      e.lo  = u >> 8;
      e.hi  = (u + 255) >> 8;
      sb.push_back(e);
      send(smp_tab[i], spk_tab[i]);
      cyc(12);
      ones = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clk_vga);
        ones += int'(bus.aud_l);
      end
      e = sb.pop_front();
      vectors++;
      if (ones < e.lo || ones > e.hi) begin
        miscompares++;
        $display("FAIL mix_duty smp=%h spk=%b ones %0d want %0d..%0d", e.smp, e.spk, ones, e.lo, e.hi);
      end
    end
  endtask

  task automatic test_full_scale;
    int ones;
    send(16'h7FFF, 1'b1);
    cyc(12);
    ones = 0;
    for (int k = 0; k < 65536; k++) begin
      @(negedge clk_vga);
      ones += int'(bus.aud_l);
    end
    vectors++;
    if (ones != 65535) begin
      miscompares++; $display("FAIL full_scale_ones got %0d want 65535", ones);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    n = 0;
    while (bus.aud_l !== 1'b1 && n < 20) begin
      @(negedge clk_vga);
      n++;
    end
    vectors++;
    if (bus.aud_l !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_aud got %b want 1", bus.aud_l);
    end
    vectors++;
    if (dut.acc === 17'd0) begin
      miscompares++; $display("FAIL pre_reset_acc got %h want nonzero", dut.acc);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.aud_l !== 1'b0 || bus.aud_r !== 1'b0) begin
      miscompares++; $display("FAIL midreset_aud got %b%b want 00", bus.aud_l, bus.aud_r);
    end
    vectors++;
    if (bus.ramp_done !== 1'b0) begin
      miscompares++; $display("FAIL midreset_ramp_done got %b want 0", bus.ramp_done);
    end
    vectors++;
    if (dut.g !== 9'd0 || dut.acc !== 17'd0) begin
      miscompares++; $display("FAIL midreset_state g %0d acc %h want 0 0", dut.g, dut.acc);
    end
    cyc(3);
    reset = 1'b0;
    n = 0;
    while (dut.g !== 9'd100 && n < 1000) begin
      @(negedge clk_vga);
      n++;
    end
    vectors++;
    if (dut.g !== 9'd100) begin
      miscompares++; $display("FAIL reramp_reach_100 got %0d want 100", dut.g);
    end
  endtask

  task automatic test_mute_ramp;
    int   n, step, max_step;
    logic [8:0] prev;
    bus.mute = 1'b1;
    cyc(3);
    vectors++;
    if (dut.g !== 9'd100 || dut.state !== ST_RAMP_DOWN) begin
      miscompares++; $display("FAIL mute_turn g %0d state %0d want 100 3", dut.g, dut.state);
    end
    prev = dut.g;
    max_step = 0;
    n = 0;
    while (dut.g !== 9'd0 && n < 2000) begin
      @(negedge clk_vga);
      n++;
      step = int'(prev) - int'(dut.g);
      if (step < 0) step = -step;
      if (step > max_step) max_step = step;
      prev = dut.g;
    end
    vectors++;
    if (n < 390 || n > 410) begin
      miscompares++; $display("FAIL ramp_down_time got %0d cycles want 390..410", n);
    end
    vectors++;
    if (max_step > 1) begin
      miscompares++; $display("FAIL ramp_down_step got %0d want <=1", max_step);
    end
    send(16'h7FFF, 1'b1);
    cyc(20);
    vectors++;
    if (dut.g !== 9'd0 || bus.ramp_done !== 1'b0) begin
      miscompares++; $display("FAIL muted_hold g %0d ramp_done %b want 0 0", dut.g, bus.ramp_done);
    end
    check_alternating("muted", 32);
  endtask

  initial begin
    bus.snd_toggle = 1'b0;
    bus.tandy_snd  = 16'h0000;
    bus.speaker_in = 1'b0;
    bus.mute       = 1'b0;
    test_reset();
    test_silence();
    test_capture();
    test_mix();
    test_full_scale();
    test_reset_mid_run();
    test_mute_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
